// File: rtl/alu_ctrl_pkg.sv
// Shared constants and state encoding for the shared-ALU sequencer.
package alu_ctrl_pkg;

    localparam logic [1:0] ALUOP_LDST   = 2'd0;
    localparam logic [1:0] ALUOP_BRANCH = 2'd1;
    localparam logic [1:0] ALUOP_RTYPE  = 2'd2;

    // Funccode is {funct7[5], ..., funct3}; only the codes in use are named.
    localparam logic [9:0] FUNC_ADD = 10'd0;
    localparam logic [9:0] FUNC_SUB = 10'd256;
    localparam logic [9:0] FUNC_OR  = 10'd6;
    localparam logic [9:0] FUNC_AND = 10'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant selection; the pointer names the favoured requester
// when both are asserted. Pointer bookkeeping lives with the caller.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       pointer,
    output logic [1:0] grant,
    output logic       grant_idx
);

    always_comb begin
        grant     = 2'b00;
        grant_idx = 1'b0;
        case (req)
            2'b01: begin
                grant     = 2'b01;
                grant_idx = 1'b0;
            end
            2'b10: begin
                grant     = 2'b10;
                grant_idx = 1'b1;
            end
            2'b11: begin
                grant     = pointer ? 2'b10 : 2'b01;
                grant_idx = pointer;
            end
            default: begin
                grant     = 2'b00;
                grant_idx = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters: accepts one op, holds the
// operands for a settle time, captures result/flags and returns a tagged response.
//
//   state | meaning
//   IDLE  | arbitrating, ready offered to the granted requester
//   EXEC  | operands driven into the ALU, settle counter running
//   RESP  | captured response presented until rsp_ready
module alu_share_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int FUNC_W        = 10,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [1:0]        r0_aluop,
    input  logic [FUNC_W-1:0] r0_funccode,
    input  logic [WIDTH-1:0]  r0_a,
    input  logic [WIDTH-1:0]  r0_b,

    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [1:0]        r1_aluop,
    input  logic [FUNC_W-1:0] r1_funccode,
    input  logic [WIDTH-1:0]  r1_a,
    input  logic [WIDTH-1:0]  r1_b,

    output logic [1:0]        alu_aluop,
    output logic [FUNC_W-1:0] alu_funccode,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic              alu_zero,
    input  logic              alu_overflow,
    input  logic              alu_carryout,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [WIDTH-1:0]  rsp_result,
    output logic              rsp_zero,
    output logic              rsp_overflow,
    output logic              rsp_carryout,

    output logic              busy,
    output logic [15:0]       ops_done
);

    localparam int CNT_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);

    generate
        if (SETTLE_CYCLES < 1) begin : g_bad_settle
            $error("alu_share_ctrl: SETTLE_CYCLES must be at least 1");
        end
    endgenerate

    state_t             state_q, state_d;
    logic               rr_q, rr_d;
    logic               id_q, id_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         alu_aluop_q, alu_aluop_d;
    logic [FUNC_W-1:0]  alu_funccode_q, alu_funccode_d;
    logic [WIDTH-1:0]   alu_a_q, alu_a_d;
    logic [WIDTH-1:0]   alu_b_q, alu_b_d;
    logic [WIDTH-1:0]   rsp_result_q, rsp_result_d;
    logic               rsp_zero_q, rsp_zero_d;
    logic               rsp_overflow_q, rsp_overflow_d;
    logic               rsp_carryout_q, rsp_carryout_d;
    logic [15:0]        ops_done_q, ops_done_d;

    logic [1:0]         req;
    logic [1:0]         grant;
    logic               grant_idx;
    logic               in_idle;
    logic               accept;

    assign req = {r1_valid, r0_valid};

    rr_arb2 u_arb (
        .req       (req),
        .pointer   (rr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign in_idle  = (state_q == IDLE);
    assign r0_ready = in_idle && grant[0];
    assign r1_ready = in_idle && grant[1];
    // The arbiter only grants an asserted request, so any grant is a handshake.
    assign accept   = in_idle && (grant != 2'b00);

    always_comb begin
        state_d        = state_q;
        rr_d           = rr_q;
        id_d           = id_q;
        cnt_d          = cnt_q;
        alu_aluop_d    = alu_aluop_q;
        alu_funccode_d = alu_funccode_q;
        alu_a_d        = alu_a_q;
        alu_b_d        = alu_b_q;
        rsp_result_d   = rsp_result_q;
        rsp_zero_d     = rsp_zero_q;
        rsp_overflow_d = rsp_overflow_q;
        rsp_carryout_d = rsp_carryout_q;
        ops_done_d     = ops_done_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    alu_aluop_d    = grant_idx ? r1_aluop    : r0_aluop;
                    alu_funccode_d = grant_idx ? r1_funccode : r0_funccode;
                    alu_a_d        = grant_idx ? r1_a        : r0_a;
                    alu_b_d        = grant_idx ? r1_b        : r0_b;
                    id_d           = grant_idx;
                    rr_d           = ~grant_idx;
                    cnt_d          = CNT_W'(SETTLE_CYCLES);
                    state_d        = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == CNT_W'(1)) begin
                    rsp_result_d   = alu_result;
                    rsp_zero_d     = alu_zero;
                    rsp_overflow_d = alu_overflow;
                    rsp_carryout_d = alu_carryout;
                    state_d        = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    ops_done_d = ops_done_q + 16'd1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            rr_q           <= 1'b0;
            id_q           <= 1'b0;
            cnt_q          <= '0;
            alu_aluop_q    <= '0;
            alu_funccode_q <= '0;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            rsp_result_q   <= '0;
            rsp_zero_q     <= 1'b0;
            rsp_overflow_q <= 1'b0;
            rsp_carryout_q <= 1'b0;
            ops_done_q     <= '0;
        end else begin
            state_q        <= state_d;
            rr_q           <= rr_d;
            id_q           <= id_d;
            cnt_q          <= cnt_d;
            alu_aluop_q    <= alu_aluop_d;
            alu_funccode_q <= alu_funccode_d;
            alu_a_q        <= alu_a_d;
            alu_b_q        <= alu_b_d;
            rsp_result_q   <= rsp_result_d;
            rsp_zero_q     <= rsp_zero_d;
            rsp_overflow_q <= rsp_overflow_d;
            rsp_carryout_q <= rsp_carryout_d;
            ops_done_q     <= ops_done_d;
        end
    end

    assign alu_aluop    = alu_aluop_q;
    assign alu_funccode = alu_funccode_q;
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;

    // rsp_valid and busy decode straight from the registered state, so both are 0 out of reset.
    assign rsp_valid    = (state_q == RESP);
    assign rsp_id       = id_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_zero     = rsp_zero_q;
    assign rsp_overflow = rsp_overflow_q;
    assign rsp_carryout = rsp_carryout_q;

    assign busy         = !in_idle;
    assign ops_done     = ops_done_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a behavioural ALU and a response scoreboard.
module tb_alu_share_ctrl;
    import alu_ctrl_pkg::*;

    localparam int W  = 32;
    localparam int FW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst_n;

    logic          r0_valid, r1_valid, r0_ready, r1_ready;
    logic [1:0]    r0_aluop, r1_aluop, alu_aluop;
    logic [FW-1:0] r0_funccode, r1_funccode, alu_funccode;
    logic [W-1:0]  r0_a, r0_b, r1_a, r1_b, alu_a, alu_b, alu_result, rsp_result;
    logic          alu_zero, alu_overflow, alu_carryout;
    logic          rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_overflow, rsp_carryout, busy;
    logic [15:0]   ops_done;

    logic          b_r0_valid, b_r1_valid, b_r0_ready, b_r1_ready;
    logic [1:0]    b_r0_aluop, b_r1_aluop, b_alu_aluop;
    logic [FW-1:0] b_r0_funccode, b_r1_funccode, b_alu_funccode;
    logic [W-1:0]  b_r0_a, b_r0_b, b_r1_a, b_r1_b, b_alu_a, b_alu_b, b_alu_result, b_rsp_result;
    logic          b_alu_zero, b_alu_overflow, b_alu_carryout;
    logic          b_rsp_valid, b_rsp_ready, b_rsp_id, b_rsp_zero, b_rsp_overflow, b_rsp_carryout, b_busy;
    logic [15:0]   b_ops_done;

    function automatic logic [W+2:0] alu_f(input logic [1:0] op, input logic [FW-1:0] fc,
                                          input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0]   s;
        logic [W-1:0] r;
        logic         c, v, sub;
        sub = (op == ALUOP_BRANCH) || (op == ALUOP_RTYPE && fc == FUNC_SUB);
        c = 1'b0;
        v = 1'b0;
        if (op == ALUOP_RTYPE && fc == FUNC_OR) begin
            r = a | b;
        end else if (op == ALUOP_RTYPE && fc == FUNC_AND) begin
            r = a & b;
        end else if (op == ALUOP_LDST || sub || (op == ALUOP_RTYPE && fc == FUNC_ADD)) begin
            s = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{W{1'b0}}, sub};
            r = s[W-1:0];
            c = s[W];
            v = sub ? ((a[W-1] != b[W-1]) && (r[W-1] != a[W-1]))
                    : ((a[W-1] == b[W-1]) && (r[W-1] != a[W-1]));
        end else begin
            r = '0;
        end
        return {c, v, (r == '0), r};
    endfunction

    assign {alu_carryout, alu_overflow, alu_zero, alu_result} = alu_f(alu_aluop, alu_funccode, alu_a, alu_b);
    assign {b_alu_carryout, b_alu_overflow, b_alu_zero, b_alu_result} =
        alu_f(b_alu_aluop, b_alu_funccode, b_alu_a, b_alu_b);

    alu_share_ctrl #(.WIDTH(W), .FUNC_W(FW), .SETTLE_CYCLES(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_aluop(r0_aluop), .r0_funccode(r0_funccode),
        .r0_a(r0_a), .r0_b(r0_b),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_aluop(r1_aluop), .r1_funccode(r1_funccode),
        .r1_a(r1_a), .r1_b(r1_b),
        .alu_aluop(alu_aluop), .alu_funccode(alu_funccode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .alu_carryout(alu_carryout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow), .rsp_carryout(rsp_carryout),
        .busy(busy), .ops_done(ops_done)
    );

    alu_share_ctrl #(.WIDTH(W), .FUNC_W(FW), .SETTLE_CYCLES(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(b_r0_valid), .r0_ready(b_r0_ready), .r0_aluop(b_r0_aluop),
        .r0_funccode(b_r0_funccode), .r0_a(b_r0_a), .r0_b(b_r0_b),
        .r1_valid(b_r1_valid), .r1_ready(b_r1_ready), .r1_aluop(b_r1_aluop),
        .r1_funccode(b_r1_funccode), .r1_a(b_r1_a), .r1_b(b_r1_b),
        .alu_aluop(b_alu_aluop), .alu_funccode(b_alu_funccode), .alu_a(b_alu_a), .alu_b(b_alu_b),
        .alu_result(b_alu_result), .alu_zero(b_alu_zero), .alu_overflow(b_alu_overflow),
        .alu_carryout(b_alu_carryout),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_id(b_rsp_id),
        .rsp_result(b_rsp_result), .rsp_zero(b_rsp_zero), .rsp_overflow(b_rsp_overflow),
        .rsp_carryout(b_rsp_carryout), .busy(b_busy), .ops_done(b_ops_done)
    );

    typedef struct {
        logic         id;
        logic [W-1:0] res;
        logic         z;
        logic         v;
        logic         c;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic push(input logic id, input logic [W-1:0] res, input logic z, input logic v, input logic c);
        exp_t e;
        e.id = id; e.res = res; e.z = z; e.v = v; e.c = c;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready(input logic who, output int acc);
        acc = -1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if ((who ? r1_ready : r0_ready) === 1'b1) begin
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        chk(who ? "accept_r1" : "accept_r0", 32'(acc >= 0), 32'd1);
    endtask

    task automatic wait_rsp(input string tag, output int t);
        exp_t e;
        t = -1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (rsp_valid === 1'b1) begin
                t = cyc;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_rsp_seen"}, 32'(t >= 0), 32'd1);
        chk({tag, "_sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
        if (t >= 0 && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({tag, "_id"},     32'(rsp_id),       32'(e.id));
            chk({tag, "_result"}, rsp_result,        e.res);
            chk({tag, "_zero"},   32'(rsp_zero),     32'(e.z));
            chk({tag, "_ovf"},    32'(rsp_overflow), 32'(e.v));
            chk({tag, "_carry"},  32'(rsp_carryout), 32'(e.c));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, t, m;
        rst_n = 1'b0; rsp_ready = 1'b0; b_rsp_ready = 1'b0;
        r0_valid = 0; r0_aluop = 0; r0_funccode = 0; r0_a = 0; r0_b = 0;
        r1_valid = 0; r1_aluop = 0; r1_funccode = 0; r1_a = 0; r1_b = 0;
        b_r0_valid = 0; b_r0_aluop = 0; b_r0_funccode = 0; b_r0_a = 0; b_r0_b = 0;
        b_r1_valid = 0; b_r1_aluop = 0; b_r1_funccode = 0; b_r1_a = 0; b_r1_b = 0;
        tick(); tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_ops_done", 32'(ops_done), 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_aluop", 32'(alu_aluop), 0);
        chk("rst_rsp_result", rsp_result, 0);
        rst_n = 1'b1;
        tick();

        // Single R-type AND
        rsp_ready = 1'b1;
        r0_aluop = 2'd2; r0_funccode = 10'd7; r0_a = 32'h7; r0_b = 32'h5; r0_valid = 1'b1;
        push(1'b0, 32'h5, 1'b0, 1'b0, 1'b0);
        wait_ready(1'b0, acc);
        tick();
        r0_valid = 1'b0;
        #1;
        chk("and_r0_ready_low", 32'(r0_ready), 0);
        chk("and_busy", 32'(busy), 1);
        chk("and_alu_aluop", 32'(alu_aluop), 2);
        chk("and_alu_func", 32'(alu_funccode), 7);
        chk("and_alu_a", alu_a, 32'h7);
        chk("and_alu_b", alu_b, 32'h5);
        wait_rsp("and", t);
        chk("and_latency", 32'(t - acc), 2);
        tick();
        chk("and_rsp_valid_fall", 32'(rsp_valid), 0);
        chk("and_ops_done", 32'(ops_done), 1);
        chk("and_idle", 32'(busy), 0);
        chk("and_alu_a_held", alu_a, 32'h7);

        // Contention right after reset: r0 favoured, then fairness flips to r1
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        r0_aluop = 2'd2; r0_funccode = 10'd256; r0_a = 32'h17; r0_b = 32'hd; r0_valid = 1'b1;
        r1_aluop = 2'd2; r1_funccode = 10'd0;   r1_a = 32'h17; r1_b = 32'hd; r1_valid = 1'b1;
        push(1'b0, 32'ha,  1'b0, 1'b0, 1'b1);
        push(1'b1, 32'h24, 1'b0, 1'b0, 1'b0);
        push(1'b0, 32'h1f, 1'b0, 1'b0, 1'b0);
        wait_ready(1'b0, acc);
        chk("cont_r1_loses", 32'(r1_ready), 0);
        tick();
        r0_funccode = 10'd6;
        wait_rsp("cont0", t);
        tick();
        wait_ready(1'b1, acc);
        chk("cont_r0_loses", 32'(r0_ready), 0);
        tick();
        r1_valid = 1'b0;
        wait_rsp("cont1", t);
        tick();
        wait_ready(1'b0, acc);
        tick();
        r0_valid = 1'b0;
        wait_rsp("cont2", t);
        tick();
        chk("cont_ops_done", 32'(ops_done), 3);

        // Backpressure on a signed-overflow add, r1 queued behind it
        rsp_ready = 1'b0;
        r0_aluop = 2'd0; r0_funccode = 10'd0; r0_a = 32'h7fffffff; r0_b = 32'h1; r0_valid = 1'b1;
        push(1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
        wait_ready(1'b0, acc);
        tick();
        r0_valid = 1'b0;
        r1_aluop = 2'd1; r1_funccode = 10'd0; r1_a = 32'h1; r1_b = 32'h1; r1_valid = 1'b1;
        push(1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
        wait_rsp("bp", t);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_valid", 32'(rsp_valid), 1);
            chk("bp_hold_result", rsp_result, 32'h80000000);
            chk("bp_hold_ovf", 32'(rsp_overflow), 1);
            chk("bp_hold_carry", 32'(rsp_carryout), 0);
            chk("bp_hold_busy", 32'(busy), 1);
            chk("bp_r1_blocked", 32'(r1_ready), 0);
        end
        rsp_ready = 1'b1;
        m = cyc;
        #1;
        chk("bp_r1_blocked_hs", 32'(r1_ready), 0);
        tick();
        wait_ready(1'b1, acc);
        chk("bp_next_accept_cycle", 32'(acc), 32'(m + 1));
        tick();
        r1_valid = 1'b0;
        wait_rsp("branch", t);
        tick();

        // Unsigned carry-out add
        r0_aluop = 2'd0; r0_funccode = 10'd0; r0_a = 32'hffffffff; r0_b = 32'h1; r0_valid = 1'b1;
        push(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        wait_ready(1'b0, acc);
        tick();
        r0_valid = 1'b0;
        wait_rsp("addc", t);
        tick();
        chk("addc_ops_done", 32'(ops_done), 6);

        // Reset during EXEC drops the op and restores the rr pointer
        r0_aluop = 2'd2; r0_funccode = 10'd0; r0_a = 32'h3; r0_b = 32'h4; r0_valid = 1'b1;
        wait_ready(1'b0, acc);
        tick();
        r0_valid = 1'b0;
        chk("mid_busy", 32'(busy), 1);
        rst_n = 1'b0;
        tick();
        chk("mid_rsp_valid", 32'(rsp_valid), 0);
        chk("mid_busy_clr", 32'(busy), 0);
        chk("mid_alu_a", alu_a, 0);
        chk("mid_alu_func", 32'(alu_funccode), 0);
        chk("mid_rsp_result", rsp_result, 0);
        chk("mid_ops_done", 32'(ops_done), 0);
        rst_n = 1'b1;
        r0_valid = 1'b1;
        r1_valid = 1'b1;
        #1;
        chk("mid_rr_r0_ready", 32'(r0_ready), 1);
        chk("mid_rr_r1_ready", 32'(r1_ready), 0);
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        tick();
        chk("mid_drop_no_accept", 32'(busy), 0);
        tick();
        chk("mid_no_rsp", 32'(rsp_valid), 0);
        chk("sb_drained", 32'(sb_q.size()), 0);

        // SETTLE_CYCLES=3 instance: latency and ops_done wrap
        force u_dut_b.ops_done_q = 16'hffff;
        tick();
        tick();
        release u_dut_b.ops_done_q;
        #1;
        chk("b_forced", 32'(b_ops_done), 32'hffff);
        b_rsp_ready = 1'b1;
        b_r0_aluop = 2'd0; b_r0_funccode = 10'd0; b_r0_a = 32'h2; b_r0_b = 32'h3; b_r0_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (b_r0_ready === 1'b1) begin
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        chk("b_accept", 32'(acc >= 0), 1);
        tick();
        b_r0_valid = 1'b0;
        chk("b_busy", 32'(b_busy), 1);
        t = -1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (b_rsp_valid === 1'b1) begin
                t = cyc;
                break;
            end
            @(negedge clk);
        end
        chk("b_rsp_seen", 32'(t >= 0), 1);
        chk("b_latency", 32'(t - acc), 4);
        chk("b_result", b_rsp_result, 32'h5);
        chk("b_id", 32'(b_rsp_id), 0);
        chk("b_ops_before", 32'(b_ops_done), 32'hffff);
        tick();
        chk("b_ops_wrap", 32'(b_ops_done), 0);
        chk("b_rsp_fall", 32'(b_rsp_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
